npc_btb_gen: RTL and testbench

Next-PC generator for the 5-stage RV32I pipeline, sitting directly upstream of the IF segment register and driving its PC input every cycle. Combines a direct-mapped branch target buffer with 2-bit saturating counters (predicts in IF), JAL redirect from ID, and misprediction recovery from EX. Also keeps branch/mispredict statistics counters for the branch-prediction lab report.

---
 rtl/npc_btb_gen_pkg.sv | 30 +++
 rtl/npc_btb_gen_btb_entry_array.sv | 79 +++++++
 rtl/npc_btb_gen.sv | 109 ++++++++++
 tb/tb_npc_btb_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/npc_btb_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npc_btb_gen_pkg
// Brief    : Shared constants, counter encodings and saturating helpers for
//            the next-PC generator and its branch target buffer.
// Revision : 1.0
// ============================================================================
package npc_btb_gen_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_STEP = 32'd4;

  // 2-bit saturating predictor states
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? c : c - 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/npc_btb_gen_btb_entry_array.sv
`default_nettype none
// ============================================================================
// Module   : btb_entry_array
// Brief    : Direct-mapped BTB storage (valid/tag/target/ctr) with a
//            combinational lookup port and a single registered update port.
// Revision : 1.0
// ============================================================================
module btb_entry_array
  import npc_btb_gen_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:2] lookup_pc_i,
  output logic            hit_o,
  output logic [1:0]      ctr_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:2] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - 2 - IDX;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;

  assign lk_idx = lookup_pc_i[IDX+1:2];
  assign lk_tag = lookup_pc_i[XLEN-1:IDX+2];
  assign up_idx = upd_pc_i[IDX+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDX+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed
  always_comb begin
    hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    ctr_o    = ctr_q[lk_idx];
    target_o = target_q[lk_idx];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  // Train the entry of the resolving branch: strengthen/allocate on taken, weaken on not-taken hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_en_i) begin
      if (upd_taken_i) begin
        if (up_hit) begin
          ctr_q[up_idx]    <= sat_inc(ctr_q[up_idx]);
          target_q[up_idx] <= upd_target_i;
        end else begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= upd_target_i;
          ctr_q[up_idx]    <= CTR_WT;
        end
      end else if (up_hit) begin
        ctr_q[up_idx] <= sat_dec(ctr_q[up_idx]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/npc_btb_gen.sv
`default_nettype none
// ============================================================================
// Module   : npc_btb_gen
// Brief    : Next-PC generator: BTB prediction in IF, JAL redirect from ID,
//            JALR / mispredict recovery from EX, plus branch statistics.
// Revision : 1.0
// ============================================================================
module npc_btb_gen
  import npc_btb_gen_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_IF,
  input  logic            JalD,
  input  logic [XLEN-1:0] JalTargetD,
  input  logic            JalrE,
  input  logic [XLEN-1:0] JalrTargetE,
  input  logic            BrValidE,
  input  logic            BrTakenE,
  input  logic [XLEN-1:0] BrPCE,
  input  logic [XLEN-1:0] BrTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  input  logic            UpdEn,
  output logic [XLEN-1:0] NPC,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  output logic            FlushE,
  output logic            FlushD,
  output logic [XLEN-1:0] BrCount,
  output logic [XLEN-1:0] MissCount
);

  logic            btb_hit;
  logic [1:0]      btb_ctr;
  logic [XLEN-1:0] btb_target;
  logic            mispredict;
  logic            upd_fire;
  logic [XLEN-1:0] br_count_q, br_count_d;
  logic [XLEN-1:0] miss_count_q, miss_count_d;

  assign upd_fire = BrValidE & UpdEn;

  btb_entry_array #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc_i  (PC_IF[XLEN-1:2]),
    .hit_o        (btb_hit),
    .ctr_o        (btb_ctr),
    .target_o     (btb_target),
    .upd_en_i     (upd_fire),
    .upd_pc_i     (BrPCE[XLEN-1:2]),
    .upd_taken_i  (BrTakenE),
    .upd_target_i (BrTargetE)
  );

  // IF prediction, EX mispredict detection and redirect priority (EX over ID over BTB)
  always_comb begin
    PredTakenF  = btb_hit & btb_ctr[1];
    PredTargetF = PredTakenF ? btb_target : PC_IF + INSTR_STEP;
    mispredict  = BrValidE & ((BrTakenE != PredTakenE) |
                              (BrTakenE & (BrTargetE != PredTargetE)));
    NPC    = PredTargetF;
    FlushE = 1'b0;
    FlushD = 1'b0;
    if (mispredict) begin
      NPC    = BrTakenE ? BrTargetE : BrPCE + INSTR_STEP;
      FlushE = 1'b1;
    end else if (JalrE) begin
      NPC    = JalrTargetE;
      FlushE = 1'b1;
    end else if (JalD) begin
      NPC    = JalTargetD;
      FlushD = 1'b1;
    end
  end

  // Statistics next-state: count every retired branch update and its mispredicts
  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (upd_fire) begin
      br_count_d = br_count_q + 32'd1;
      if (mispredict) begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign BrCount   = br_count_q;
  assign MissCount = miss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_npc_btb_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_btb_gen
// Brief    : Directed self-checking bench for npc_btb_gen (ENTRIES=8).
// Revision : 1.0
// ============================================================================
module tb_npc_btb_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF;
  logic        JalD;
  logic [31:0] JalTargetD;
  logic        JalrE;
  logic [31:0] JalrTargetE;
  logic        BrValidE;
  logic        BrTakenE;
  logic [31:0] BrPCE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        UpdEn;
  logic [31:0] NPC;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        FlushE;
  logic        FlushD;
  logic [31:0] BrCount;
  logic [31:0] MissCount;

  int n_assert = 0;
  int n_fail   = 0;

  npc_btb_gen #(.ENTRIES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_IF       (PC_IF),
    .JalD        (JalD),
    .JalTargetD  (JalTargetD),
    .JalrE       (JalrE),
    .JalrTargetE (JalrTargetE),
    .BrValidE    (BrValidE),
    .BrTakenE    (BrTakenE),
    .BrPCE       (BrPCE),
    .BrTargetE   (BrTargetE),
    .PredTakenE  (PredTakenE),
    .PredTargetE (PredTargetE),
    .UpdEn       (UpdEn),
    .NPC         (NPC),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .FlushE      (FlushE),
    .FlushD      (FlushD),
    .BrCount     (BrCount),
    .MissCount   (MissCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    JalD = 1'b0; JalTargetD = 32'h0; JalrE = 1'b0; JalrTargetE = 32'h0;
    BrValidE = 1'b0; BrTakenE = 1'b0; BrPCE = 32'h0; BrTargetE = 32'h0;
    PredTakenE = 1'b0; PredTargetE = 32'h0; UpdEn = 1'b0;
  endtask

  task automatic br(input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptgt, input logic upd);
    BrValidE = 1'b1; BrTakenE = tk; BrPCE = pc; BrTargetE = tgt;
    PredTakenE = ptk; PredTargetE = ptgt; UpdEn = upd;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; clr(); PC_IF = 32'h100;
    #1;
    chk("rst_npc", NPC, 32'h104);
    chk("rst_ptf", {31'b0, PredTakenF}, 32'd0);
    chk("rst_brcnt", BrCount, 32'd0);
    chk("rst_miss", MissCount, 32'd0);
    chk("rst_flushe", {31'b0, FlushE}, 32'd0);
    chk("rst_flushd", {31'b0, FlushD}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // ---------------- first taken branch allocates ----------------
    @(negedge clk); clr(); PC_IF = 32'h300; br(1, 32'h200, 32'h80, 0, 32'h204, 1);
    #1;
    chk("alloc_npc", NPC, 32'h80);
    chk("alloc_flushe", {31'b0, FlushE}, 32'd1);
    chk("alloc_flushd", {31'b0, FlushD}, 32'd0);
    @(negedge clk); clr(); PC_IF = 32'h200;
    #1;
    chk("hit_ptf", {31'b0, PredTakenF}, 32'd1);
    chk("hit_npc", NPC, 32'h80);
    chk("hit_ptgt", PredTargetF, 32'h80);
    chk("hit_brcnt", BrCount, 32'd1);
    chk("hit_miss", MissCount, 32'd1);

    // ---------------- not taken twice: 10 -> 01 -> 00 ----------------
    @(negedge clk); clr(); PC_IF = 32'h500; br(0, 32'h200, 32'h80, 1, 32'h80, 1);
    #1;
    chk("nt1_npc", NPC, 32'h204);
    chk("nt1_flushe", {31'b0, FlushE}, 32'd1);
    @(negedge clk); clr(); PC_IF = 32'h200; br(0, 32'h200, 32'h80, 0, 32'h204, 1);
    #1;
    chk("nt2_flushe", {31'b0, FlushE}, 32'd0);
    chk("nt2_ptf_wnt", {31'b0, PredTakenF}, 32'd0);
    chk("nt2_npc", NPC, 32'h204);
    @(negedge clk); clr(); PC_IF = 32'h200;
    #1;
    chk("nt_done_npc", NPC, 32'h204);
    chk("nt_done_brcnt", BrCount, 32'd3);
    chk("nt_done_miss", MissCount, 32'd2);

    // ---------------- saturation at 00, climb back to 11, target retrain ----------------
    @(negedge clk); clr(); PC_IF = 32'h700; br(1, 32'h200, 32'h80, 0, 32'h204, 1);
    @(negedge clk); clr(); PC_IF = 32'h200;
    #1;
    chk("sat_lo_ptf", {31'b0, PredTakenF}, 32'd0);
    br(1, 32'h200, 32'h80, 0, 32'h204, 1);
    @(negedge clk); clr(); PC_IF = 32'h200;
    #1;
    chk("wt_ptf", {31'b0, PredTakenF}, 32'd1);
    chk("wt_brcnt", BrCount, 32'd5);
    chk("wt_miss", MissCount, 32'd4);
    br(1, 32'h200, 32'h80, 1, 32'h80, 1);
    #1;
    chk("correct_flushe", {31'b0, FlushE}, 32'd0);
    @(negedge clk); br(1, 32'h200, 32'h80, 1, 32'h80, 1);
    @(negedge clk); br(0, 32'h200, 32'h80, 1, 32'h80, 1);
    @(negedge clk); clr(); PC_IF = 32'h200;
    #1;
    chk("sat_hi_ptf", {31'b0, PredTakenF}, 32'd1);
    chk("sat_hi_brcnt", BrCount, 32'd8);
    chk("sat_hi_miss", MissCount, 32'd5);
    PC_IF = 32'h700; br(1, 32'h200, 32'h88, 1, 32'h80, 1);
    #1;
    chk("tgt_miss_npc", NPC, 32'h88);
    chk("tgt_miss_flushe", {31'b0, FlushE}, 32'd1);
    @(negedge clk); clr(); PC_IF = 32'h200;
    #1;
    chk("retarget_npc", NPC, 32'h88);
    chk("retarget_miss", MissCount, 32'd6);

    // ---------------- JAL vs EX mispredict, stalled update ----------------
    @(negedge clk); clr(); PC_IF = 32'h800; JalD = 1'b1; JalTargetD = 32'h400;
    br(1, 32'h610, 32'h300, 0, 32'h614, 0);
    #1;
    chk("prio_npc", NPC, 32'h300);
    chk("prio_flushe", {31'b0, FlushE}, 32'd1);
    chk("prio_flushd", {31'b0, FlushD}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stall_brcnt", BrCount, 32'd9);
      chk("stall_npc", NPC, 32'h300);
    end
    PC_IF = 32'h610;
    #1;
    chk("stall_noalloc_ptf", {31'b0, PredTakenF}, 32'd0);
    UpdEn = 1'b1;
    @(negedge clk); clr(); PC_IF = 32'h610;
    #1;
    chk("upd_once_brcnt", BrCount, 32'd10);
    chk("upd_once_miss", MissCount, 32'd7);
    chk("upd_once_npc", NPC, 32'h300);

    // ---------------- JAL alone, JALR over JAL ----------------
    PC_IF = 32'h800; JalD = 1'b1; JalTargetD = 32'h400;
    #1;
    chk("jal_npc", NPC, 32'h400);
    chk("jal_flushd", {31'b0, FlushD}, 32'd1);
    chk("jal_flushe", {31'b0, FlushE}, 32'd0);
    JalrE = 1'b1; JalrTargetE = 32'h1234;
    #1;
    chk("jalr_npc", NPC, 32'h1234);
    chk("jalr_flushe", {31'b0, FlushE}, 32'd1);
    chk("jalr_flushd", {31'b0, FlushD}, 32'd0);

    // ---------------- aliasing eviction and wraparound ----------------
    @(negedge clk); clr(); PC_IF = 32'h800; br(1, 32'h220, 32'h900, 0, 32'h224, 1);
    @(negedge clk); clr(); PC_IF = 32'h200;
    #1;
    chk("evict_ptf", {31'b0, PredTakenF}, 32'd0);
    chk("evict_npc", NPC, 32'h204);
    PC_IF = 32'h220;
    #1;
    chk("alias_npc", NPC, 32'h900);
    chk("alias_brcnt", BrCount, 32'd11);
    PC_IF = 32'hFFFF_FFFC;
    #1;
    chk("wrap_npc", NPC, 32'h0);
    chk("wrap_ptgt", PredTargetF, 32'h0);
    br(0, 32'hFFFF_FFFC, 32'h40, 1, 32'h40, 0);
    #1;
    chk("wrap_rec_npc", NPC, 32'h0);

    // ---------------- asynchronous reset mid-update ----------------
    @(negedge clk); clr(); PC_IF = 32'h220; br(1, 32'h240, 32'h500, 0, 32'h244, 1);
    #2; rst = 1'b1;
    #1;
    chk("arst_brcnt", BrCount, 32'd0);
    chk("arst_miss", MissCount, 32'd0);
    chk("arst_npc", NPC, 32'h500);
    clr();
    #1;
    chk("arst_lookup_npc", NPC, 32'h224);
    br(1, 32'h240, 32'h500, 0, 32'h244, 1);
    @(negedge clk); rst = 1'b0; clr(); PC_IF = 32'h240;
    #1;
    chk("arst_hold_npc", NPC, 32'h244);
    chk("arst_hold_brcnt", BrCount, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
